mem_port_arbiter: RTL and testbench



---
 rtl/lsu_defines.sv | 60 ++++++
 rtl/lsu_pkg.sv | 16 +
 rtl/uncache_lane_align.sv | 25 ++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_defines.sv
// LSU-wide transfer typedefs and the two memory-side channel interfaces.
// Requesters hold valid and request fields until the memory side raises mready.
package lsu_defs_pkg;

    typedef logic [2:0] Size;

    typedef enum logic {
        DOP_READ,
        DOP_WRITE
    } Dcache_op;

endpackage

interface DCACHE2MEMORY;
    import lsu_defs_pkg::*;

    logic           dvalid;
    logic           dready;
    Dcache_op       op;
    logic [31:0]    addr;
    logic [127:0]   ddata;
    logic           mready;
    logic           mvalid;
    logic [127:0]   mdata;

    modport memory (
        input  dvalid, dready, op, addr, ddata,
        output mready, mvalid, mdata
    );

    modport dcache (
        output dvalid, dready, op, addr, ddata,
        input  mready, mvalid, mdata
    );
endinterface

interface UNCACHE2MEMORY;
    import lsu_defs_pkg::*;

    logic           uvalid;
    logic           uready;
    logic           wen;
    logic [31:0]    uaddr;
    logic [31:0]    udata;
    logic [3:0]     ustrobe;
    Size            usize;
    logic           mready;
    logic           mvalid;
    logic [31:0]    mdata;

    modport memory (
        input  uvalid, uready, wen, uaddr, udata, ustrobe, usize,
        output mready, mvalid, mdata
    );

    modport uncache (
        output uvalid, uready, wen, uaddr, udata, ustrobe, usize,
        input  mready, mvalid, mdata
    );
endinterface

// File: rtl/lsu_pkg.sv
// Arbiter-local types and constants shared by the memory-port arbiter.
// Holds the arbitration FSM encoding and the full-line request constants.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        D_REQ,
        D_RESP,
        U_REQ,
        U_RESP
    } arb_state_e;

    localparam logic [15:0] LINE_STROBE = 16'hFFFF;
    localparam logic [2:0]  LINE_SIZE   = 3'd4;

endpackage

// File: rtl/uncache_lane_align.sv
// Places a 32-bit uncached word onto the 128-bit bus and picks the
// returning word out of a 128-bit response. Purely combinational.
module uncache_lane_align (
    input  logic [1:0]   wr_lane,
    input  logic [1:0]   rd_lane,
    input  logic         wen,
    input  logic [31:0]  udata,
    input  logic [3:0]   ustrobe,
    input  logic [127:0] rdata,
    output logic [127:0] wdata,
    output logic [15:0]  strobe,
    output logic [31:0]  rd_word
);

    // Replicate the word into all lanes; only the addressed lane is enabled.
    always_comb begin
        wdata   = {4{udata}};
        strobe  = 16'h0000;
        if (wen) begin
            strobe = {12'h000, ustrobe} << {wr_lane, 2'b00};
        end
        rd_word = rdata[32*rd_lane +: 32];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the 128-bit memory port between the dcache line channel and the
// uncached word channel, one outstanding transaction at a time.
module mem_port_arbiter
    import lsu_pkg::*;
    import lsu_defs_pkg::*;
#(
    parameter bit UNC_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    DCACHE2MEMORY.memory         dc,
    UNCACHE2MEMORY.memory        uc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_wen,
    output logic                 out_uncached,
    output logic [31:0]          out_addr,
    output logic [127:0]         out_wdata,
    output logic [15:0]          out_strobe,
    output logic [2:0]           out_size,
    input  logic                 in_rvalid,
    input  logic [127:0]         in_rdata,
    output logic                 out_rready
);

    arb_state_e  state_q, state_d;
    logic        last_u_q, last_u_d;
    logic [1:0]  lane_q, lane_d;

    logic [127:0] al_wdata;
    logic [15:0]  al_strobe;
    logic [31:0]  al_rword;
    logic         dc_wr;

    // Line requests are always line aligned, so the low nibble is dropped.
    logic         unused_addr_bits;
    assign unused_addr_bits = ^dc.addr[3:0];

    assign dc_wr = (dc.op == DOP_WRITE);

    uncache_lane_align u_align (
        .wr_lane (uc.uaddr[3:2]),
        .rd_lane (lane_q),
        .wen     (uc.wen),
        .udata   (uc.udata),
        .ustrobe (uc.ustrobe),
        .rdata   (in_rdata),
        .wdata   (al_wdata),
        .strobe  (al_strobe),
        .rd_word (al_rword)
    );

    // State, fairness bit and read lane registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_u_q <= !UNC_FIRST;
            lane_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            last_u_q <= last_u_d;
            lane_q   <= lane_d;
        end
    end

    // Next state: arbitrate in IDLE, advance on request and response handshakes.
    always_comb begin
        state_d  = state_q;
        last_u_d = last_u_q;
        lane_d   = lane_q;
        unique case (state_q)
            IDLE: begin
                if (dc.dvalid && (!uc.uvalid || last_u_q)) begin
                    state_d  = D_REQ;
                    last_u_d = 1'b0;
                end else if (uc.uvalid) begin
                    state_d  = U_REQ;
                    last_u_d = 1'b1;
                    lane_d   = uc.uaddr[3:2];
                end
            end
            D_REQ: begin
                if (out_ready) state_d = D_RESP;
            end
            D_RESP: begin
                if (in_rvalid && dc.dready) state_d = IDLE;
            end
            U_REQ: begin
                if (out_ready) state_d = U_RESP;
            end
            U_RESP: begin
                if (in_rvalid && uc.uready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus and channel outputs: only the owner sees handshakes, the rest is 0.
    always_comb begin
        out_valid    = 1'b0;
        out_wen      = 1'b0;
        out_uncached = 1'b0;
        out_addr     = 32'h0;
        out_wdata    = 128'h0;
        out_strobe   = 16'h0;
        out_size     = 3'd0;
        out_rready   = 1'b0;
        dc.mready    = 1'b0;
        dc.mvalid    = 1'b0;
        dc.mdata     = 128'h0;
        uc.mready    = 1'b0;
        uc.mvalid    = 1'b0;
        uc.mdata     = 32'h0;
        unique case (state_q)
            D_REQ: begin
                out_valid  = 1'b1;
                out_wen    = dc_wr;
                out_addr   = {dc.addr[31:4], 4'b0000};
                out_wdata  = dc.ddata;
                out_strobe = dc_wr ? LINE_STROBE : 16'h0;
                out_size   = LINE_SIZE;
                dc.mready  = out_ready;
            end
            D_RESP: begin
                dc.mvalid  = in_rvalid;
                dc.mdata   = in_rdata;
                out_rready = dc.dready;
            end
            U_REQ: begin
                out_valid    = 1'b1;
                out_wen      = uc.wen;
                out_uncached = 1'b1;
                out_addr     = uc.uaddr;
                out_wdata    = al_wdata;
                out_strobe   = al_strobe;
                out_size     = uc.usize;
                uc.mready    = out_ready;
            end
            U_RESP: begin
                uc.mvalid  = in_rvalid;
                uc.mdata   = al_rword;
                out_rready = uc.uready;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: tasks drive and check timing,
// a negedge scoreboard checks every request and response payload.
module tb_mem_port_arbiter;
    import lsu_defs_pkg::*;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  strobe;
        logic         wen;
        logic         unc;
        logic [2:0]   size;
    } req_t;

    typedef struct {
        logic [127:0] data;
        logic         chk;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         out_valid, out_ready, out_wen, out_uncached;
    logic [31:0]  out_addr;
    logic [127:0] out_wdata;
    logic [15:0]  out_strobe;
    logic [2:0]   out_size;
    logic         in_rvalid;
    logic [127:0] in_rdata;
    logic         out_rready;

    int tests = 0;
    int fails = 0;

    req_t  req_q[$];
    resp_t dresp_q[$];
    resp_t uresp_q[$];

    DCACHE2MEMORY  dcif ();
    UNCACHE2MEMORY ucif ();

    mem_port_arbiter #(.UNC_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .dc           (dcif.memory),
        .uc           (ucif.memory),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_wen      (out_wen),
        .out_uncached (out_uncached),
        .out_addr     (out_addr),
        .out_wdata    (out_wdata),
        .out_strobe   (out_strobe),
        .out_size     (out_size),
        .in_rvalid    (in_rvalid),
        .in_rdata     (in_rdata),
        .out_rready   (out_rready)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare every handshake against the queued expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (req_q.size() == 0) begin
                fails++;
                $display("FAIL req_unexpected: got addr=%h with nothing expected", out_addr);
            end else begin
                req_t r;
                r = req_q.pop_front();
                if ({out_addr, out_wdata, out_strobe, out_wen, out_uncached, out_size} !==
                    {r.addr, r.wdata, r.strobe, r.wen, r.unc, r.size}) begin
                    fails++;
                    $display("FAIL req_fields: got addr=%h wdata=%h strb=%h wen=%b unc=%b size=%0d, want addr=%h wdata=%h strb=%h wen=%b unc=%b size=%0d",
                             out_addr, out_wdata, out_strobe, out_wen, out_uncached, out_size,
                             r.addr, r.wdata, r.strobe, r.wen, r.unc, r.size);
                end
            end
        end
        if (dcif.mvalid === 1'b1 && dcif.dready === 1'b1) begin
            tests++;
            if (dresp_q.size() == 0) begin
                fails++;
                $display("FAIL dresp_unexpected: got %h with nothing expected", dcif.mdata);
            end else begin
                resp_t e;
                e = dresp_q.pop_front();
                if (e.chk && dcif.mdata !== e.data) begin
                    fails++;
                    $display("FAIL dresp_data: got %h want %h", dcif.mdata, e.data);
                end
            end
        end
        if (ucif.mvalid === 1'b1 && ucif.uready === 1'b1) begin
            tests++;
            if (uresp_q.size() == 0) begin
                fails++;
                $display("FAIL uresp_unexpected: got %h with nothing expected", ucif.mdata);
            end else begin
                resp_t e;
                e = uresp_q.pop_front();
                if (e.chk && ucif.mdata !== e.data[31:0]) begin
                    fails++;
                    $display("FAIL uresp_data: got %h want %h", ucif.mdata, e.data[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        tests++;
        if ({out_valid, out_rready, dcif.mready, dcif.mvalid, ucif.mready, ucif.mvalid} !== 6'b0) begin
            fails++;
            $display("FAIL reset_handshake: got %b want 000000",
                     {out_valid, out_rready, dcif.mready, dcif.mvalid, ucif.mready, ucif.mvalid});
        end
        tests++;
        if ({out_addr, out_wdata, out_strobe, out_size} !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h strb=%h size=%0d want all 0", out_addr, out_strobe, out_size);
        end
        cyc();
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: out_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_dcache_read();
        cyc();
        dcif.dvalid = 1'b1;
        dcif.op     = DOP_READ;
        dcif.addr   = 32'h1000_0014;
        dcif.ddata  = '0;
        dcif.dready = 1'b1;
        out_ready   = 1'b1;
        req_q.push_back('{32'h1000_0010, 128'h0, 16'h0, 1'b0, 1'b0, 3'd4});
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL dr_grant_latency: out_valid got %b want 0", out_valid);
        end
        cyc();
        @(negedge clk);
        tests++;
        if ({out_valid, dcif.mready, out_uncached, ucif.mready} !== 4'b1100) begin
            fails++;
            $display("FAIL dr_req: got %b want 1100", {out_valid, dcif.mready, out_uncached, ucif.mready});
        end
        cyc();
        dcif.dvalid = 1'b0;
        in_rvalid   = 1'b1;
        in_rdata    = {8{16'hAAAA}};
        dresp_q.push_back('{{8{16'hAAAA}}, 1'b1});
        @(negedge clk);
        tests++;
        if ({dcif.mvalid, out_rready, ucif.mvalid, out_valid} !== 4'b1100) begin
            fails++;
            $display("FAIL dr_resp: got %b want 1100", {dcif.mvalid, out_rready, ucif.mvalid, out_valid});
        end
        cyc();
        in_rvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, dcif.mvalid, out_rready} !== 3'b000) begin
            fails++;
            $display("FAIL dr_idle: got %b want 000", {out_valid, dcif.mvalid, out_rready});
        end
    endtask

    task automatic test_uc_write();
        cyc();
        ucif.uvalid  = 1'b1;
        ucif.wen     = 1'b1;
        ucif.uaddr   = 32'hBFD0_0008;
        ucif.udata   = 32'h1234_5678;
        ucif.ustrobe = 4'b0011;
        ucif.usize   = 3'd2;
        ucif.uready  = 1'b1;
        out_ready    = 1'b1;
        req_q.push_back('{32'hBFD0_0008, {4{32'h1234_5678}}, 16'h0300, 1'b1, 1'b1, 3'd2});
        cyc();
        @(negedge clk);
        tests++;
        if ({out_valid, out_uncached, ucif.mready, dcif.mready} !== 4'b1110) begin
            fails++;
            $display("FAIL uw_req: got %b want 1110", {out_valid, out_uncached, ucif.mready, dcif.mready});
        end
        cyc();
        ucif.uvalid = 1'b0;
        in_rvalid   = 1'b1;
        in_rdata    = '0;
        uresp_q.push_back('{128'h0, 1'b0});
        @(negedge clk);
        tests++;
        if ({ucif.mvalid, out_rready, dcif.mvalid} !== 3'b110) begin
            fails++;
            $display("FAIL uw_resp: got %b want 110", {ucif.mvalid, out_rready, dcif.mvalid});
        end
        cyc();
        in_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_uc_read();
        cyc();
        ucif.uvalid  = 1'b1;
        ucif.wen     = 1'b0;
        ucif.uaddr   = 32'hBFD0_000C;
        ucif.udata   = 32'h0;
        ucif.ustrobe = 4'hF;
        ucif.usize   = 3'd2;
        ucif.uready  = 1'b1;
        req_q.push_back('{32'hBFD0_000C, 128'h0, 16'h0, 1'b0, 1'b1, 3'd2});
        cyc();
        cyc();
        ucif.uvalid = 1'b0;
        ucif.uaddr  = 32'h0;
        in_rvalid   = 1'b1;
        in_rdata    = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F};
        uresp_q.push_back('{{96'h0, 32'hDEAD_BEEF}, 1'b1});
        @(negedge clk);
        tests++;
        if (ucif.mdata !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL ur_lane: mdata got %h want deadbeef", ucif.mdata);
        end
        cyc();
        in_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [11:0] ov;
        logic [3:0]  grants;
        ov     = '0;
        grants = '0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dcif.dvalid  = 1'b1;
        dcif.op      = DOP_WRITE;
        dcif.addr    = 32'h2000_003C;
        dcif.ddata   = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
        dcif.dready  = 1'b1;
        ucif.uvalid  = 1'b1;
        ucif.wen     = 1'b0;
        ucif.uaddr   = 32'h8000_0004;
        ucif.udata   = 32'h5555_AAAA;
        ucif.ustrobe = 4'hF;
        ucif.usize   = 3'd2;
        ucif.uready  = 1'b1;
        out_ready    = 1'b1;
        in_rdata     = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        for (int k = 0; k < 2; k++) begin
            req_q.push_back('{32'h8000_0004, {4{32'h5555_AAAA}}, 16'h0, 1'b0, 1'b1, 3'd2});
            req_q.push_back('{32'h2000_0030, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,
                              16'hFFFF, 1'b1, 1'b0, 3'd4});
            uresp_q.push_back('{{96'h0, 32'h2222_2222}, 1'b1});
            dresp_q.push_back('{128'h0, 1'b0});
        end
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) cyc();
            in_rvalid = (k % 3 == 0);
            @(negedge clk);
            ov[12-k] = out_valid;
            if (out_valid === 1'b1) grants = {grants[2:0], out_uncached};
        end
        tests++;
        if (ov !== 12'b010010010010) begin
            fails++;
            $display("FAIL fair_cadence: out_valid trace got %b want 010010010010", ov);
        end
        tests++;
        if (grants !== 4'b1010) begin
            fails++;
            $display("FAIL fair_order: grants got %b want 1010 (U,D,U,D)", grants);
        end
        cyc();
        dcif.dvalid = 1'b0;
        ucif.uvalid = 1'b0;
        in_rvalid   = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fail_line("fair_drain", out_valid);
        end
    endtask

    task automatic fail_line(input string name, input logic got);
        fails++;
        $display("FAIL %s: got %b want 0", name, got);
    endtask

    task automatic test_stalls();
        cyc();
        dcif.dvalid = 1'b1;
        dcif.op     = DOP_READ;
        dcif.addr   = 32'h3000_0008;
        dcif.ddata  = '0;
        dcif.dready = 1'b0;
        out_ready   = 1'b0;
        in_rvalid   = 1'b1;
        req_q.push_back('{32'h3000_0000, 128'h0, 16'h0, 1'b0, 1'b0, 3'd4});
        @(negedge clk);
        tests++;
        if ({out_valid, out_rready, dcif.mvalid} !== 3'b000) begin
            fails++;
            $display("FAIL st_idle_rvalid: got %b want 000", {out_valid, out_rready, dcif.mvalid});
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                ucif.uvalid  = 1'b1;
                ucif.uaddr   = 32'h9000_0000;
                ucif.wen     = 1'b0;
                ucif.udata   = 32'h0;
                ucif.ustrobe = 4'h0;
                ucif.usize   = 3'd2;
                ucif.uready  = 1'b1;
            end
            @(negedge clk);
            tests++;
            if ({out_valid, out_uncached, dcif.mready, ucif.mready, out_rready, dcif.mvalid} !== 6'b100000) begin
                fails++;
                $display("FAIL st_req_hold[%0d]: got %b want 100000", i,
                         {out_valid, out_uncached, dcif.mready, ucif.mready, out_rready, dcif.mvalid});
            end
        end
        cyc();
        out_ready = 1'b1;
        in_rvalid = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, dcif.mready, ucif.mready} !== 3'b110) begin
            fails++;
            $display("FAIL st_req_go: got %b want 110", {out_valid, dcif.mready, ucif.mready});
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 0) begin
                dcif.dvalid = 1'b0;
                in_rvalid   = 1'b1;
                in_rdata    = {8{16'hBBBB}};
            end
            @(negedge clk);
            tests++;
            if ({dcif.mvalid, out_rready, out_valid, ucif.mready, ucif.mvalid} !== 5'b10000) begin
                fails++;
                $display("FAIL st_resp_hold[%0d]: got %b want 10000", i,
                         {dcif.mvalid, out_rready, out_valid, ucif.mready, ucif.mvalid});
            end
        end
        cyc();
        dcif.dready = 1'b1;
        dresp_q.push_back('{{8{16'hBBBB}}, 1'b1});
        @(negedge clk);
        tests++;
        if ({dcif.mvalid, out_rready} !== 2'b11) begin
            fails++;
            $display("FAIL st_resp_go: got %b want 11", {dcif.mvalid, out_rready});
        end
        cyc();
        in_rvalid = 1'b0;
        req_q.push_back('{32'h9000_0000, 128'h0, 16'h0, 1'b0, 1'b1, 3'd2});
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fail_line("st_idle_between", out_valid);
        end
        cyc();
        @(negedge clk);
        tests++;
        if ({out_valid, out_uncached, ucif.mready} !== 3'b111) begin
            fails++;
            $display("FAIL st_u_grant: got %b want 111", {out_valid, out_uncached, ucif.mready});
        end
        cyc();
        ucif.uvalid = 1'b0;
        in_rvalid   = 1'b1;
        in_rdata    = {96'h0, 32'hCAFE_F00D};
        uresp_q.push_back('{{96'h0, 32'hCAFE_F00D}, 1'b1});
        cyc();
        in_rvalid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        cyc();
        ucif.uvalid  = 1'b1;
        ucif.uaddr   = 32'h7000_0004;
        ucif.wen     = 1'b0;
        ucif.udata   = 32'h0;
        ucif.ustrobe = 4'h0;
        ucif.usize   = 3'd2;
        ucif.uready  = 1'b0;
        out_ready    = 1'b1;
        req_q.push_back('{32'h7000_0004, 128'h0, 16'h0, 1'b0, 1'b1, 3'd2});
        cyc();
        cyc();
        ucif.uvalid = 1'b0;
        dcif.dvalid = 1'b1;
        dcif.op     = DOP_READ;
        dcif.addr   = 32'h4000_0020;
        dcif.ddata  = '0;
        dcif.dready = 1'b1;
        in_rvalid   = 1'b1;
        in_rdata    = {4{32'h7777_7777}};
        rst         = 1'b1;
        @(negedge clk);
        tests++;
        if ({ucif.mvalid, out_rready} !== 2'b10) begin
            fails++;
            $display("FAIL rm_uresp_stall: got %b want 10", {ucif.mvalid, out_rready});
        end
        cyc();
        rst       = 1'b0;
        in_rvalid = 1'b0;
        req_q.push_back('{32'h4000_0020, 128'h0, 16'h0, 1'b0, 1'b0, 3'd4});
        @(negedge clk);
        tests++;
        if ({out_valid, out_rready, dcif.mready, dcif.mvalid, ucif.mready, ucif.mvalid} !== 6'b0) begin
            fails++;
            $display("FAIL rm_after_rst: got %b want 000000",
                     {out_valid, out_rready, dcif.mready, dcif.mvalid, ucif.mready, ucif.mvalid});
        end
        cyc();
        @(negedge clk);
        tests++;
        if ({out_valid, out_uncached, dcif.mready} !== 3'b101) begin
            fails++;
            $display("FAIL rm_d_grant: got %b want 101", {out_valid, out_uncached, dcif.mready});
        end
        cyc();
        dcif.dvalid = 1'b0;
        in_rvalid   = 1'b1;
        in_rdata    = {4{32'h1357_9BDF}};
        dresp_q.push_back('{{4{32'h1357_9BDF}}, 1'b1});
        cyc();
        in_rvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        out_ready    = 1'b0;
        in_rvalid    = 1'b0;
        in_rdata     = '0;
        dcif.dvalid  = 1'b0;
        dcif.dready  = 1'b0;
        dcif.op      = DOP_READ;
        dcif.addr    = '0;
        dcif.ddata   = '0;
        ucif.uvalid  = 1'b0;
        ucif.uready  = 1'b0;
        ucif.wen     = 1'b0;
        ucif.uaddr   = '0;
        ucif.udata   = '0;
        ucif.ustrobe = '0;
        ucif.usize   = '0;

        test_reset();
        test_dcache_read();
        test_uc_write();
        test_uc_read();
        test_fairness();
        test_stalls();
        test_reset_mid();

        tests++;
        if (req_q.size() != 0 || dresp_q.size() != 0 || uresp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: left req=%0d dresp=%0d uresp=%0d want 0 0 0",
                     req_q.size(), dresp_q.size(), uresp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
